// File: rtl/msi_bus_pkg.sv
// MSI shared-bus definitions: op codes, arbiter states and field widths.
// Shared by the bus arbiter, the cache controllers and the memory model.
package msi_bus_pkg;

   localparam int OP_W   = 3;
   localparam int ADDR_W = 5;
   localparam int LINE_W = 16;

   localparam logic [OP_W-1:0] OP_NONE  = 3'd0;
   localparam logic [OP_W-1:0] OP_RD    = 3'd1;
   localparam logic [OP_W-1:0] OP_UPGR  = 3'd2;
   localparam logic [OP_W-1:0] OP_FLUSH = 3'd3;
   localparam logic [OP_W-1:0] OP_RDX   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_ADDR,
      S_SNOOP,
      S_MEM,
      S_DONE
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after the last owner,
// wrapping, returned as one-hot grant plus index.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         any
);

   logic [W-1:0] cand;

   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = last;
      for (int k = 0; k < N; k++) begin
         cand = (cand == W'(N - 1)) ? '0 : cand + W'(1);
         if (!any && req[cand]) begin
            any       = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/msi_bus_arbiter.sv
// MSI shared-bus controller: round-robin grant, one-cycle op broadcast,
// snoop-flush capture, memory sequencing and bus_done completion pulse.
module msi_bus_arbiter
   import msi_bus_pkg::*;
#(
   parameter int NCACHE        = 4,
   parameter int GRANT_TIMEOUT = 15,
   parameter int SNOOP_WIN     = 2,
   localparam int OW           = $clog2(NCACHE)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NCACHE-1:0]        cache_request,
   output logic [NCACHE-1:0]        cache_grant,
   input  logic [OP_W*NCACHE-1:0]   cache_op,
   input  logic [ADDR_W*NCACHE-1:0] cache_addr,
   input  logic [LINE_W*NCACHE-1:0] cache_dout,
   input  logic [NCACHE-1:0]        cache_done,
   output logic [OP_W-1:0]          bus_op,
   output logic [ADDR_W-1:0]        bus_addr,
   output logic [LINE_W-1:0]        bus_data,
   output logic                     bus_done,
   output logic [OW-1:0]            bus_owner,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [LINE_W-1:0]        mem_wdata,
   input  logic [LINE_W-1:0]        mem_rdata,
   input  logic                     mem_ack
);

   arb_state_e state_q, state_d;
   logic [OW-1:0] owner_q, owner_d, bus_owner_q, bus_owner_d;
   logic [NCACHE-1:0] grant_q, grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d, bus_addr_q, bus_addr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [OP_W-1:0] bus_op_q, bus_op_d;
   logic [LINE_W-1:0] bus_data_q, bus_data_d, mem_wdata_q, mem_wdata_d;
   logic [7:0] cnt_q, cnt_d;
   logic bus_done_q, bus_done_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;

   logic [OP_W-1:0]   op_a   [NCACHE];
   logic [ADDR_W-1:0] addr_a [NCACHE];
   logic [LINE_W-1:0] dout_a [NCACHE];
   logic [NCACHE-1:0] rr_gnt;
   logic [OW-1:0] rr_idx, snp_idx;
   logic rr_any, snp_hit;

   always_comb begin
      for (int i = 0; i < NCACHE; i++) begin
         op_a[i]   = cache_op[OP_W*i +: OP_W];
         addr_a[i] = cache_addr[ADDR_W*i +: ADDR_W];
         dout_a[i] = cache_dout[LINE_W*i +: LINE_W];
      end
   end

   rr_arbiter #(.N(NCACHE), .W(OW)) u_rr (
      .req  (cache_request),
      .last (owner_q),
      .gnt  (rr_gnt),
      .idx  (rr_idx),
      .any  (rr_any)
   );

   // Descending scan so the lowest-index flusher wins.
   always_comb begin
      snp_hit = 1'b0;
      snp_idx = '0;
      for (int j = NCACHE - 1; j >= 0; j--) begin
         if (OW'(j) != owner_q && cache_done[j] &&
             op_a[j] == OP_FLUSH && addr_a[j] == addr_q) begin
            snp_hit = 1'b1;
            snp_idx = OW'(j);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      bus_owner_d = bus_owner_q;
      grant_d     = grant_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      bus_op_d    = OP_NONE;
      bus_addr_d  = '0;
      bus_data_d  = bus_data_q;
      bus_done_d  = 1'b0;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (rr_any) begin
               owner_d     = rr_idx;
               bus_owner_d = rr_idx;
               grant_d     = rr_gnt;
               cnt_d       = '0;
               state_d     = S_GRANT;
            end
         end
         S_GRANT: begin
            cnt_d = cnt_q + 8'd1;
            if (cache_request[owner_q] && op_a[owner_q] != OP_NONE) begin
               addr_d = addr_a[owner_q];
               if (op_a[owner_q] == OP_FLUSH) begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = addr_a[owner_q];
                  mem_wdata_d = dout_a[owner_q];
                  bus_data_d  = dout_a[owner_q];
                  state_d     = S_MEM;
               end else begin
                  bus_op_d   = op_a[owner_q];
                  bus_addr_d = addr_a[owner_q];
                  state_d    = S_ADDR;
               end
            end else if (!cache_request[owner_q] ||
                         cnt_q == 8'(GRANT_TIMEOUT - 1)) begin
               grant_d = '0;
               state_d = S_IDLE;
            end
         end
         S_ADDR: begin
            cnt_d = '0;
            if (bus_op_q == OP_UPGR) begin
               bus_done_d = 1'b1;
               grant_d    = '0;
               state_d    = S_DONE;
            end else begin
               state_d = S_SNOOP;
            end
         end
         S_SNOOP: begin
            if (snp_hit) begin
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_q;
               mem_wdata_d = dout_a[snp_idx];
               bus_data_d  = dout_a[snp_idx];
               state_d     = S_MEM;
            end else if (cnt_q == 8'(SNOOP_WIN - 1)) begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = addr_q;
               state_d    = S_MEM;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_MEM: begin
            if (mem_ack) begin
               mem_req_d  = 1'b0;
               bus_done_d = 1'b1;
               grant_d    = '0;
               state_d    = S_DONE;
               if (!mem_we_q) bus_data_d = mem_rdata;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         owner_q     <= OW'(NCACHE - 1);
         bus_owner_q <= '0;
         grant_q     <= '0;
         addr_q      <= '0;
         cnt_q       <= '0;
         bus_op_q    <= OP_NONE;
         bus_addr_q  <= '0;
         bus_data_q  <= '0;
         bus_done_q  <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         bus_owner_q <= bus_owner_d;
         grant_q     <= grant_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         bus_op_q    <= bus_op_d;
         bus_addr_q  <= bus_addr_d;
         bus_data_q  <= bus_data_d;
         bus_done_q  <= bus_done_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign cache_grant = grant_q;
   assign bus_op      = bus_op_q;
   assign bus_addr    = bus_addr_q;
   assign bus_data    = bus_data_q;
   assign bus_done    = bus_done_q;
   assign bus_owner   = bus_owner_q;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;

endmodule
